// File: rtl/aes_mem_bridge.sv
// Shared word buffer and ownership sequencer between the ARM host and the AES/GF core.
// The host and the core take turns owning the buffer across two phases: encryption, then MAC.
module aes_mem_bridge #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_memory,
  input  logic             en_r,
  input  logic             en_w,
  input  logic [5:0]       addr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  input  logic             done,
  input  logic             done2,
  input  logic [WIDTH-1:0] mac_in,
  output logic             done_arm,
  output logic             done_arm2,
  input  logic             host_we,
  input  logic             host_re,
  input  logic [5:0]       host_addr,
  input  logic [WIDTH-1:0] host_wdata,
  output logic [WIDTH-1:0] host_rdata,
  output logic             host_rvalid,
  input  logic             host_start,
  input  logic             host_ack,
  output logic             host_err,
  output logic             irq,
  output logic [WIDTH-1:0] mac,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_HOST = 3'd0,
    S_RUN1 = 3'd1,
    S_RES1 = 3'd2,
    S_RUN2 = 3'd3,
    S_RES2 = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             done_q, done2_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [WIDTH-1:0] q_q, rdata_q, mac_q;
  logic             rvalid_q, err_q, irq_q, arm_q, arm2_q, busy_q;

  logic             core_live, host_live;
  logic             done_rise, done2_rise;
  logic             err_d;
  logic             mem_we;
  logic [5:0]       mem_waddr;
  logic [WIDTH-1:0] mem_wdata;

  assign done_rise  = done & ~done_q;
  assign done2_rise = done2 & ~done2_q;
  assign core_live  = (state_q == S_RUN1) || (state_q == S_RUN2);
  assign host_live  = ~core_live;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_HOST:  if (host_start) state_d = S_RUN1;
      S_RUN1:  if (done_rise)  state_d = S_RES1;
      S_RES1:  if (host_ack)   state_d = S_RUN2;
      S_RUN2:  if (done2_rise) state_d = S_RES2;
      S_RES2:  if (host_start) state_d = S_RUN1;
      default: state_d = S_HOST;
    endcase
  end

  // A start is only legal once a full two-phase round has finished (or never started).
  always_comb begin
    err_d = 1'b0;
    if (core_live && (host_we || host_re))
      err_d = 1'b1;
    if (host_start && (state_q == S_RUN1 || state_q == S_RES1 || state_q == S_RUN2))
      err_d = 1'b1;
    if (host_ack && (state_q != S_RES1))
      err_d = 1'b1;
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = host_addr;
    mem_wdata = host_wdata;
    if (core_live && en_memory && en_w) begin
      mem_we    = 1'b1;
      mem_waddr = addr;
      mem_wdata = d;
    end else if (host_live && host_we) begin
      mem_we = 1'b1;
    end
  end

  // Buffer contents survive reset so a mid-run abort leaves the data readable.
  always_ff @(posedge clk) begin
    if (mem_we)
      mem_q[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_HOST;
      done_q   <= 1'b0;
      done2_q  <= 1'b0;
      q_q      <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      irq_q    <= 1'b0;
      arm_q    <= 1'b0;
      arm2_q   <= 1'b0;
      busy_q   <= 1'b0;
      mac_q    <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= done;
      done2_q  <= done2;
      err_q    <= err_d;
      rvalid_q <= host_live && host_re;
      if (host_live && host_re)
        rdata_q <= mem_q[host_addr];
      if (core_live && en_memory && en_r)
        q_q <= mem_q[addr];
      if ((state_q == S_RUN2) && done2_rise)
        mac_q <= mac_in;
      busy_q   <= (state_d == S_RUN1) || (state_d == S_RUN2);
      arm_q    <= (state_d == S_RUN1);
      arm2_q   <= (state_d == S_RUN2);
      irq_q    <= (state_d == S_RES1) || (state_d == S_RES2);
    end
  end

  assign q           = q_q;
  assign host_rdata  = rdata_q;
  assign host_rvalid = rvalid_q;
  assign host_err    = err_q;
  assign irq         = irq_q;
  assign done_arm    = arm_q;
  assign done_arm2   = arm2_q;
  assign busy        = busy_q;
  assign mac         = mac_q;

endmodule

// File: tb/tb_aes_mem_bridge.sv
// Bench for aes_mem_bridge: directed vector table, mid-run reset sequence, then
// randomized traffic checked against an ownership-level reference model.
module tb_aes_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_memory, en_r, en_w;
  logic [5:0]  addr;
  logic [15:0] d, q;
  logic        done, done2;
  logic [15:0] mac_in;
  logic        done_arm, done_arm2;
  logic        host_we, host_re;
  logic [5:0]  host_addr;
  logic [15:0] host_wdata, host_rdata;
  logic        host_rvalid, host_start, host_ack, host_err, irq, busy;
  logic [15:0] mac;

  always #5 clk = ~clk;

  aes_mem_bridge #(.DEPTH(64), .WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .en_memory(en_memory), .en_r(en_r), .en_w(en_w), .addr(addr), .d(d), .q(q),
    .done(done), .done2(done2), .mac_in(mac_in),
    .done_arm(done_arm), .done_arm2(done_arm2),
    .host_we(host_we), .host_re(host_re), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .host_start(host_start), .host_ack(host_ack), .host_err(host_err),
    .irq(irq), .mac(mac), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int we, re, haddr, hwd, start, ack, mem, r, w, caddr, cd, dn, dn2, macin;
    int flg;  // {busy, done_arm, done_arm2, irq, host_err, host_rvalid}
    int eq, erd, emac;
  } vec_t;

  vec_t tbl[27];

  // Reference model: who owns the buffer, which pass is pending, whether a result waits.
  logic [15:0] rmem [64];
  bit          core_owns, result, pdn, pdn2;
  int          pass;
  logic [15:0] mq, mrd, mmac;
  bit          mvalid, merr;

  task automatic chk1(input string nm, input int tag, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %b expected %b", nm, tag, act, exp);
    end
  endtask

  task automatic chk16(input string nm, input int tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, tag, act, exp);
    end
  endtask

  task automatic check_all(input string nm, input int tag, input logic [5:0] f,
                           input logic [15:0] eq, input logic [15:0] erd, input logic [15:0] emac);
    chk1({nm, ".busy"},      tag, busy,        f[5]);
    chk1({nm, ".done_arm"},  tag, done_arm,    f[4]);
    chk1({nm, ".done_arm2"}, tag, done_arm2,   f[3]);
    chk1({nm, ".irq"},       tag, irq,         f[2]);
    chk1({nm, ".host_err"},  tag, host_err,    f[1]);
    chk1({nm, ".rvalid"},    tag, host_rvalid, f[0]);
    chk16({nm, ".q"},        tag, q,           eq);
    chk16({nm, ".rdata"},    tag, host_rdata,  erd);
    chk16({nm, ".mac"},      tag, mac,         emac);
  endtask

  task automatic idle();
    en_memory = 1'b0; en_r = 1'b0; en_w = 1'b0; addr = '0; d = '0;
    done = 1'b0; done2 = 1'b0; mac_in = '0;
    host_we = 1'b0; host_re = 1'b0; host_addr = '0; host_wdata = '0;
    host_start = 1'b0; host_ack = 1'b0;
  endtask

  task automatic apply(input vec_t t);
    host_we = t.we[0]; host_re = t.re[0]; host_addr = t.haddr[5:0]; host_wdata = t.hwd[15:0];
    host_start = t.start[0]; host_ack = t.ack[0];
    en_memory = t.mem[0]; en_r = t.r[0]; en_w = t.w[0]; addr = t.caddr[5:0]; d = t.cd[15:0];
    done = t.dn[0]; done2 = t.dn2[0]; mac_in = t.macin[15:0];
  endtask

  // Advance the model by one clock using the inputs currently driven, then compare.
  task automatic model_cycle(input int tag);
    logic [15:0] oh, oc;
    bit drise, d2rise, in_host, res1, res2;
    oh      = rmem[host_addr];
    oc      = rmem[addr];
    drise   = done && !pdn;
    d2rise  = done2 && !pdn2;
    in_host = !core_owns && !result;
    res1    = !core_owns && result && pass == 1;
    res2    = !core_owns && result && pass == 2;
    merr = (core_owns && (host_we || host_re)) || (host_start && !(in_host || res2)) ||
           (host_ack && !res1);
    if (!core_owns) begin
      if (host_we) rmem[host_addr] = host_wdata;
      mvalid = host_re;
      if (host_re) mrd = oh;
    end else begin
      mvalid = 1'b0;
      if (en_memory && en_w) rmem[addr] = d;
      if (en_memory && en_r) mq = oc;
    end
    if (core_owns) begin
      if (pass == 1 && drise) begin
        core_owns = 1'b0; result = 1'b1;
      end else if (pass == 2 && d2rise) begin
        core_owns = 1'b0; result = 1'b1; mmac = mac_in;
      end
    end else if (res1 && host_ack) begin
      core_owns = 1'b1; pass = 2; result = 1'b0;
    end else if ((in_host || res2) && host_start) begin
      core_owns = 1'b1; pass = 1; result = 1'b0;
    end
    pdn  = done;
    pdn2 = done2;
    @(posedge clk);
    #1;
    check_all("rand", tag,
              {core_owns, core_owns && pass == 1, core_owns && pass == 2, result, merr, mvalid},
              mq, mrd, mmac);
  endtask

  initial begin
    //        we re ha hwd      st ak mem r w ca cd       dn dn2 macin    flg        q        rdata    mac
    tbl[0]  = '{1, 0, 5, 'h1234, 0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       'b000000, 'h0000, 'h0000, 'h0000};
    tbl[1]  = '{1, 0, 7, 'h7777, 0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       'b000000, 'h0000, 'h0000, 'h0000};
    tbl[2]  = '{1, 0, 3, 'h0303, 0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       'b000000, 'h0000, 'h0000, 'h0000};
    tbl[3]  = '{0, 0, 0, 0,      0, 0, 1, 1, 1, 3, 'hDEAD,  0, 0, 0,       'b000000, 'h0000, 'h0000, 'h0000};
    tbl[4]  = '{0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0,       1, 0, 0,       'b000000, 'h0000, 'h0000, 'h0000};
    tbl[5]  = '{0, 1, 3, 0,      0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       'b000001, 'h0000, 'h0303, 'h0000};
    tbl[6]  = '{0, 1, 5, 0,      0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       'b000001, 'h0000, 'h1234, 'h0000};
    tbl[7]  = '{0, 0, 0, 0,      1, 0, 0, 0, 0, 0, 0,       0, 0, 0,       'b110000, 'h0000, 'h1234, 'h0000};
    tbl[8]  = '{0, 0, 0, 0,      0, 0, 1, 1, 0, 5, 0,       0, 0, 0,       'b110000, 'h1234, 'h1234, 'h0000};
    tbl[9]  = '{0, 0, 0, 0,      0, 0, 1, 1, 1, 5, 'hBEEF,  0, 0, 0,       'b110000, 'h1234, 'h1234, 'h0000};
    tbl[10] = '{0, 0, 0, 0,      0, 0, 1, 1, 0, 5, 0,       0, 0, 0,       'b110000, 'hBEEF, 'h1234, 'h0000};
    tbl[11] = '{1, 0, 7, 'hAAAA, 0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       'b110010, 'hBEEF, 'h1234, 'h0000};
    tbl[12] = '{0, 0, 0, 0,      0, 1, 0, 0, 0, 0, 0,       0, 0, 0,       'b110010, 'hBEEF, 'h1234, 'h0000};
    tbl[13] = '{0, 1, 5, 0,      0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       'b110010, 'hBEEF, 'h1234, 'h0000};
    tbl[14] = '{0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0,       1, 0, 0,       'b000100, 'hBEEF, 'h1234, 'h0000};
    tbl[15] = '{0, 1, 5, 0,      0, 0, 0, 0, 0, 0, 0,       1, 0, 0,       'b000101, 'hBEEF, 'hBEEF, 'h0000};
    tbl[16] = '{0, 1, 7, 0,      0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       'b000101, 'hBEEF, 'h7777, 'h0000};
    tbl[17] = '{0, 0, 0, 0,      1, 0, 0, 0, 0, 0, 0,       0, 0, 0,       'b000110, 'hBEEF, 'h7777, 'h0000};
    tbl[18] = '{0, 0, 0, 0,      0, 1, 0, 0, 0, 0, 0,       0, 0, 0,       'b101000, 'hBEEF, 'h7777, 'h0000};
    tbl[19] = '{0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0,       1, 0, 0,       'b101000, 'hBEEF, 'h7777, 'h0000};
    tbl[20] = '{0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0,       0, 1, 'h5A5A,  'b000100, 'hBEEF, 'h7777, 'h5A5A};
    tbl[21] = '{0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0,       0, 1, 'h1111,  'b000100, 'hBEEF, 'h7777, 'h5A5A};
    tbl[22] = '{0, 0, 0, 0,      0, 1, 0, 0, 0, 0, 0,       0, 0, 0,       'b000110, 'hBEEF, 'h7777, 'h5A5A};
    tbl[23] = '{0, 0, 0, 0,      1, 0, 0, 0, 0, 0, 0,       0, 0, 0,       'b110000, 'hBEEF, 'h7777, 'h5A5A};
    tbl[24] = '{0, 0, 0, 0,      0, 0, 1, 0, 1, 9, 'h0909,  0, 0, 0,       'b110000, 'hBEEF, 'h7777, 'h5A5A};
    tbl[25] = '{0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0,       1, 0, 0,       'b000100, 'hBEEF, 'h7777, 'h5A5A};
    tbl[26] = '{0, 0, 0, 0,      0, 1, 0, 0, 0, 0, 0,       0, 0, 0,       'b101000, 'hBEEF, 'h7777, 'h5A5A};

    rst = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 6'b000000, 16'h0000, 16'h0000, 16'h0000);
    rst = 1'b1;

    for (int i = 0; i < 27; i++) begin
      apply(tbl[i]);
      @(posedge clk);
      #1;
      check_all("vec", i, tbl[i].flg[5:0], tbl[i].eq[15:0], tbl[i].erd[15:0], tbl[i].emac[15:0]);
    end

    // Asynchronous reset while the core owns the buffer in the MAC pass.
    idle();
    #2;
    rst = 1'b0;
    #1;
    check_all("rst_mid", 0, 6'b000000, 16'h0000, 16'h0000, 16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b1;
    host_re = 1'b1; host_addr = 6'd5;
    @(posedge clk);
    #1;
    check_all("keep5", 0, 6'b000001, 16'h0000, 16'hBEEF, 16'h0000);
    host_addr = 6'd9;
    @(posedge clk);
    #1;
    check_all("keep9", 0, 6'b000001, 16'h0000, 16'h0909, 16'h0000);
    idle();

    // Model starts from the known post-reset state, then owns every buffer word.
    core_owns = 1'b0; result = 1'b0; pass = 1; pdn = 1'b0; pdn2 = 1'b0;
    mq = 16'h0000; mrd = 16'h0909; mmac = 16'h0000; mvalid = 1'b0; merr = 1'b0;
    for (int i = 0; i < 64; i++) rmem[i] = 16'hxxxx;
    for (int i = 0; i < 64; i++) begin
      host_we = 1'b1; host_addr = 6'(i); host_wdata = 16'($urandom);
      model_cycle(1000 + i);
    end
    idle();

    for (int i = 0; i < 800; i++) begin
      host_we    = ($urandom_range(0, 3) == 0);
      host_re    = ($urandom_range(0, 2) == 0);
      host_addr  = 6'($urandom);
      host_wdata = 16'($urandom);
      host_start = ($urandom_range(0, 9) == 0);
      host_ack   = ($urandom_range(0, 9) == 0);
      en_memory  = ($urandom_range(0, 1) == 0);
      en_r       = ($urandom_range(0, 1) == 0);
      en_w       = ($urandom_range(0, 1) == 0);
      addr       = 6'($urandom);
      d          = 16'($urandom);
      done       = ($urandom_range(0, 3) == 0);
      done2      = ($urandom_range(0, 3) == 0);
      mac_in     = 16'($urandom);
      model_cycle(i);
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
